niu32_io_ctrl: RTL and testbench
================================

# niu32_io_ctrl

Parametrised memory-mapped I/O controller for the Niu32 multicycle core. It decodes bus accesses in a fixed window above `BASE_ADDR` and drives the board outputs: hex digits, red LEDs and green LEDs. It samples the board inputs (keys and switches) through synchronisers and per-channel debouncers, and records key presses in sticky edge-capture bits that can raise an interrupt. It sits between the core's memory stage and the board pins; seven-segment decoding stays outside the block.

## Interface
Parameters:
- `WORD_SIZE`, 32, bus data/address width
- `BASE_ADDR`, 32'hFFFF0000, base of the 512-byte I/O window
- `NUM_HEX`, 4, hex digits; 4*NUM_HEX ≤ WORD_SIZE
- `NUM_LEDR`, 10, red LED count
- `NUM_LEDG`, 8, green LED count
- `NUM_KEYS`, 4, key count
- `NUM_SWITCHES`, 10, switch count
- `DEBOUNCE_CYCLES`, 65536, stable cycles required before a debounced level changes; ≥ 1

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge
- `reset`, in, 1: synchronous, active-high
- `addr`, in, WORD_SIZE: byte address
- `wdata`, in, WORD_SIZE: write data
- `we`, in, 1: write strobe, one cycle per access
- `re`, in, 1: read strobe, one cycle per access
- `hit`, out, 1: combinational; addr lies in [BASE_ADDR, BASE_ADDR+0x1FF]
- `rdata`, out, WORD_SIZE: registered read data
- `rvalid`, out, 1: read data valid; one-cycle pulse
- `KEY`, in, NUM_KEYS: raw keys, active-low
- `SWITCH`, in, NUM_SWITCHES: raw switches, active-high
- `LEDR`, out, NUM_LEDR: red LEDs
- `LEDG`, out, NUM_LEDG: green LEDs
- `hex_value`, out, 4*NUM_HEX: nibble per digit; digit 0 in [3:0]
- `irq`, out, 1: key interrupt request, registered

## Operation
Register map (offset from BASE_ADDR; word-aligned, addr[1:0] ignored):
- 0x000 HEX, R/W: low 4*NUM_HEX bits; upper bits are not stored and read 0
- 0x020 LEDR, R/W: low NUM_LEDR bits
- 0x040 LEDG, R/W: low NUM_LEDG bits
- 0x100 KEY_LEVEL, RO: debounced pressed state; 1 = pressed (inverted raw)
- 0x104 KEY_EDGE, R/W1C: sticky, set on debounced 0→1 of the pressed state; writing 1 to a bit clears it
- 0x108 KEY_MASK, R/W: interrupt enables
- 0x120 SWITCH, RO: debounced switch levels

Access rules:
- Any other offset inside the window reads 0; writes to it are ignored.
- Accesses with `hit`=0 are ignored entirely: no `rvalid`, no state change.

Input path, per channel:
- 2-flop synchroniser, then debouncer.
- The debouncer counter clears whenever the synchronised input equals the current debounced output.
- Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES−1, the output flips and the counter clears.

Interrupt:
- `irq` ← |(KEY_EDGE & KEY_MASK), registered.

## Timing
- Read: `re`&`hit` in cycle N → `rdata`/`rvalid` valid in cycle N+1. `rdata` holds its value until the next read; `rvalid`=0 otherwise.
- Write: the register updates at the edge that ends cycle N; outputs change in N+1.
- `re` and `we` in the same cycle to the same register: the write is performed, and the read returns the pre-write value.
- KEY_EDGE set and W1C clear of the same bit in the same cycle: set wins.
- Input latency: a raw change stable from cycle N is visible in KEY_LEVEL/SWITCH at N+2+DEBOUNCE_CYCLES. An edge bit sets at that same edge, and `irq` follows one cycle later.
- Glitches shorter than DEBOUNCE_CYCLES never change debounced state.
- Counter width is $clog2(DEBOUNCE_CYCLES+1); no wrap is reachable.
- Reset values: LEDR, LEDG, hex_value, KEY_EDGE, KEY_MASK, debounced levels, sync flops, counters, rdata, rvalid, irq all 0.
- Reset mid-debounce discards progress. After reset, switches held high read 1 only after the full debounce latency.

## Configuration
- `NIU32_IO_IRQ_EN` defined: KEY_MASK register and `irq` logic exist as described.
- Not defined: KEY_MASK is not implemented (reads 0, writes ignored), `irq` is tied 0, and KEY_EDGE remains functional.

## Structure
- Package `niu32_io_pkg`: register offset constants (OFF_HEX, OFF_LEDR, OFF_LEDG, OFF_KEY_LEVEL, OFF_KEY_EDGE, OFF_KEY_MASK, OFF_SWITCH) and the window size, shared with the core's address decode and the assembler MIF tooling.
- Sub-module `niu32_debounce` (parameters WIDTH, DEBOUNCE_CYCLES): synchroniser, counter, level. Instantiated once for keys and once for switches.

## Test plan
Bench uses DEBOUNCE_CYCLES=4 and the default widths.
- Reset, then read every register → all read 0. Outputs are 0, `rvalid` pulses exactly once per read.
- Write 0x0000BEEF to HEX, then read → hex_value=16'hBEEF. Write 0xFFFFFFFF to LEDR → LEDR=10'h3FF, and a read returns 0x3FF.
- Drive KEY[2] low for 3 cycles, then high → KEY_LEVEL stays 0 and KEY_EDGE stays 0. Hold it low for 10 cycles → KEY_LEVEL=0x4 at cycle 6 after the change, and KEY_EDGE=0x4.
- With KEY_EDGE=0x4, write 0x4 to KEY_EDGE in the same cycle a new KEY[2] press is debounced → KEY_EDGE stays 0x4. Write 0x4 later → reads 0.
- With `NIU32_IO_IRQ_EN`: KEY_MASK=0x4 and a KEY[2] press → `irq`=1 one cycle after the edge bit sets; W1C → `irq`=0 the following cycle. Without the macro → `irq` stays 0 and KEY_MASK reads 0.
- Read at offset 0x180 and at address 0x00001000 → in-window read gives rdata=0 and `rvalid`=1; out-of-window gives `hit`=0 and no `rvalid`. Simultaneous write/read of LEDG returns the old value.

Source files
------------

// File: rtl/niu32_io_pkg.sv
// Purpose : shared register map of the Niu32 memory-mapped I/O window.
// Latency : n/a (constants and a pure helper function only).
// Backpressure: n/a.
// Offsets are relative to the window base and are also consumed by the core's
// address decode and the assembler MIF tooling, so keep them stable.
package niu32_io_pkg;

  localparam int WINDOW_SIZE = 512;

  localparam logic [8:0] OFF_HEX       = 9'h000;
  localparam logic [8:0] OFF_LEDR      = 9'h020;
  localparam logic [8:0] OFF_LEDG      = 9'h040;
  localparam logic [8:0] OFF_KEY_LEVEL = 9'h100;
  localparam logic [8:0] OFF_KEY_EDGE  = 9'h104;
  localparam logic [8:0] OFF_KEY_MASK  = 9'h108;
  localparam logic [8:0] OFF_SWITCH    = 9'h120;

  // Registers are word-aligned; the byte lane bits never select a register.
  function automatic logic [8:0] word_off(input logic [8:0] off);
    return {off[8:2], 2'b00};
  endfunction

endpackage

// File: rtl/niu32_debounce.sv
// Purpose : per-channel 2-flop synchroniser followed by a stable-count debouncer.
// Latency : a raw change stable from cycle N shows on o_level in cycle N+2+DEBOUNCE_CYCLES.
// Backpressure: none; free-running every cycle.
// Ports: clk, reset (sync, active-high); i_raw raw async inputs;
//        o_level debounced levels; o_rise one-cycle pulse, high in the cycle
//        whose closing edge raises the corresponding o_level bit.
module niu32_debounce
  import niu32_io_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_raw,
  output logic [WIDTH-1:0] o_level,
  output logic [WIDTH-1:0] o_rise
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_level;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] w_flip;

  // A channel flips once its synchronised input has disagreed with the
  // debounced level for DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_flip[i] = (r_sync2[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_level <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_level <= r_level ^ w_flip;
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_sync2[i] == r_level[i]) || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = w_flip & ~r_level;

endmodule

// File: rtl/niu32_io_ctrl.sv
// Purpose : memory-mapped I/O controller (hex/LED outputs, debounced keys/switches, key IRQ).
// Latency : reads return one cycle after re&hit; writes visible the cycle after we&hit.
// Backpressure: none; every in-window access completes in one cycle.
// Ports: clk, reset (sync, active-high); addr/wdata/we/re bus request;
//        hit (combinational window decode); rdata/rvalid registered read return;
//        KEY (active-low), SWITCH raw board inputs; LEDR, LEDG, hex_value board
//        outputs; irq registered key interrupt.
// Optional feature: define NIU32_IO_IRQ_EN to build KEY_MASK and the irq logic;
// without it KEY_MASK reads 0, ignores writes and irq is tied low.
module niu32_io_ctrl
  import niu32_io_pkg::*;
#(
  parameter int                   WORD_SIZE       = 32,
  parameter logic [WORD_SIZE-1:0] BASE_ADDR       = 32'hFFFF0000,
  parameter int                   NUM_HEX         = 4,
  parameter int                   NUM_LEDR        = 10,
  parameter int                   NUM_LEDG        = 8,
  parameter int                   NUM_KEYS        = 4,
  parameter int                   NUM_SWITCHES    = 10,
  parameter int                   DEBOUNCE_CYCLES = 65536
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [WORD_SIZE-1:0]    addr,
  input  logic [WORD_SIZE-1:0]    wdata,
  input  logic                    we,
  input  logic                    re,
  output logic                    hit,
  output logic [WORD_SIZE-1:0]    rdata,
  output logic                    rvalid,
  input  logic [NUM_KEYS-1:0]     KEY,
  input  logic [NUM_SWITCHES-1:0] SWITCH,
  output logic [NUM_LEDR-1:0]     LEDR,
  output logic [NUM_LEDG-1:0]     LEDG,
  output logic [4*NUM_HEX-1:0]    hex_value,
  output logic                    irq
);

  localparam int HEX_W = 4 * NUM_HEX;

  logic [WORD_SIZE-1:0]    w_rel;
  logic [8:0]              w_off;
  logic                    w_wr;
  logic                    w_rd;
  logic [WORD_SIZE-1:0]    w_rd_dat;
  logic [NUM_KEYS-1:0]     w_key_level;
  logic [NUM_KEYS-1:0]     w_key_rise;
  logic [NUM_KEYS-1:0]     w_edge_clr;
  logic [NUM_KEYS-1:0]     w_mask_rd;
  logic [NUM_SWITCHES-1:0] w_sw_level;
  logic [NUM_SWITCHES-1:0] w_sw_rise;
  logic                    w_unused_bits;

  logic [HEX_W-1:0]        r_hex;
  logic [NUM_LEDR-1:0]     r_ledr;
  logic [NUM_LEDG-1:0]     r_ledg;
  logic [NUM_KEYS-1:0]     r_key_edge;
  logic [WORD_SIZE-1:0]    r_rdata;
  logic                    r_rvalid;

  // Unsigned distance from the base: anything below the base wraps to a huge
  // value, so one compare covers both ends of the window.
  assign w_rel = addr - BASE_ADDR;
  assign hit   = (w_rel < WORD_SIZE'(WINDOW_SIZE));
  assign w_off = word_off(w_rel[8:0]);
  assign w_wr  = we & hit;
  assign w_rd  = re & hit;

  // Keys are inverted before debouncing so that 1 means pressed everywhere
  // downstream and the all-zero reset state means "nothing pressed".
  niu32_debounce #(
    .WIDTH           (NUM_KEYS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_db (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (~KEY),
    .o_level (w_key_level),
    .o_rise  (w_key_rise)
  );

  niu32_debounce #(
    .WIDTH           (NUM_SWITCHES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_db (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (SWITCH),
    .o_level (w_sw_level),
    .o_rise  (w_sw_rise)
  );

  assign w_edge_clr = (w_wr && (w_off == OFF_KEY_EDGE)) ? wdata[NUM_KEYS-1:0] : '0;

`ifdef NIU32_IO_IRQ_EN
  logic [NUM_KEYS-1:0] r_key_mask;
  logic                r_irq;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_mask <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_KEY_MASK)) begin
        r_key_mask <= wdata[NUM_KEYS-1:0];
      end
      r_irq <= |(r_key_edge & r_key_mask);
    end
  end

  assign w_mask_rd = r_key_mask;
  assign irq       = r_irq;
`else
  assign w_mask_rd = '0;
  assign irq       = 1'b0;
`endif

  // Read mux sees the pre-write register values, so a same-cycle read/write
  // returns the old contents.
  always_comb begin
    w_rd_dat = '0;
    case (w_off)
      OFF_HEX:       w_rd_dat[HEX_W-1:0]        = r_hex;
      OFF_LEDR:      w_rd_dat[NUM_LEDR-1:0]     = r_ledr;
      OFF_LEDG:      w_rd_dat[NUM_LEDG-1:0]     = r_ledg;
      OFF_KEY_LEVEL: w_rd_dat[NUM_KEYS-1:0]     = w_key_level;
      OFF_KEY_EDGE:  w_rd_dat[NUM_KEYS-1:0]     = r_key_edge;
      OFF_KEY_MASK:  w_rd_dat[NUM_KEYS-1:0]     = w_mask_rd;
      OFF_SWITCH:    w_rd_dat[NUM_SWITCHES-1:0] = w_sw_level;
      default:       w_rd_dat                   = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hex      <= '0;
      r_ledr     <= '0;
      r_ledg     <= '0;
      r_key_edge <= '0;
      r_rdata    <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      if (w_wr && (w_off == OFF_HEX))  r_hex  <= wdata[HEX_W-1:0];
      if (w_wr && (w_off == OFF_LEDR)) r_ledr <= wdata[NUM_LEDR-1:0];
      if (w_wr && (w_off == OFF_LEDG)) r_ledg <= wdata[NUM_LEDG-1:0];
      // Clear first, then OR in new rises: a press landing in the same cycle
      // as its W1C is never lost.
      r_key_edge <= (r_key_edge & ~w_edge_clr) | w_key_rise;
      r_rvalid   <= w_rd;
      if (w_rd) r_rdata <= w_rd_dat;
    end
  end

  assign rdata     = r_rdata;
  assign rvalid    = r_rvalid;
  assign LEDR      = r_ledr;
  assign LEDG      = r_ledg;
  assign hex_value = r_hex;

  // Address/data bits above the register widths and switch rises are not needed.
  assign w_unused_bits = &{1'b0, wdata, w_rel, w_sw_rise};

endmodule

// File: tb/tb_niu32_io_ctrl.sv
module tb_niu32_io_ctrl;

  localparam int          D    = 4;
  localparam logic [31:0] BASE = 32'hFFFF0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we, re, hit, rvalid, irq;
  logic [3:0]  KEY;
  logic [9:0]  SWITCH, LEDR;
  logic [7:0]  LEDG;
  logic [15:0] hex_value;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  niu32_io_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .hit(hit), .rdata(rdata), .rvalid(rvalid), .KEY(KEY), .SWITCH(SWITCH),
    .LEDR(LEDR), .LEDG(LEDG), .hex_value(hex_value), .irq(irq)
  );

  // ---------------- behavioural reference model ----------------
  int          cyc = 0;
  int          last_rst = 0;
  logic [3:0]  hk [64];
  logic [9:0]  hs [64];
  logic [15:0] m_hex;
  logic [9:0]  m_ledr, m_slev;
  logic [7:0]  m_ledg;
  logic [3:0]  m_klev, m_edge, m_mask;
  logic [31:0] m_rdata;
  logic        m_rvalid, m_irq;

  function automatic logic [31:0] model_read(input logic [8:0] off);
    case (off)
      9'h000: return {16'h0, m_hex};
      9'h020: return {22'h0, m_ledr};
      9'h040: return {24'h0, m_ledg};
      9'h100: return {28'h0, m_klev};
      9'h104: return {28'h0, m_edge};
`ifdef NIU32_IO_IRQ_EN
      9'h108: return {28'h0, m_mask};
`endif
      9'h120: return {22'h0, m_slev};
      default: return 32'h0;
    endcase
  endfunction

  // Debounce rule: a level flips when the synchronised sample (raw input two
  // cycles earlier, zero just after reset) has differed from it in each of the
  // last D cycles since reset.
  always @(posedge clk) begin : model
    logic [3:0] klev_n, rise, clr;
    logic [9:0] slev_n;
    logic [8:0] off;
    logic       in_win, all_k, s;
    int         c;
    cyc = cyc + 1;
    hk[cyc % 64] = ~KEY;
    hs[cyc % 64] = SWITCH;
    if (reset) begin
      m_hex = 0; m_ledr = 0; m_ledg = 0; m_klev = 0; m_slev = 0; m_edge = 0;
      m_mask = 0; m_rdata = 0; m_rvalid = 0; m_irq = 0;
      last_rst = cyc;
    end else begin
      in_win = (addr >= BASE) && (addr <= BASE + 32'h1FF);
      off    = addr[8:0] & 9'h1FC;
      klev_n = m_klev;
      slev_n = m_slev;
      if (cyc - D + 1 > last_rst) begin
        for (int ch = 0; ch < 4; ch++) begin
          all_k = 1'b1;
          for (int k = 0; k < D; k++) begin
            c = cyc - k;
            s = (c - 2 <= last_rst) ? 1'b0 : hk[(c - 2) % 64][ch];
            if (s == m_klev[ch]) all_k = 1'b0;
          end
          if (all_k) klev_n[ch] = ~m_klev[ch];
        end
        for (int ch = 0; ch < 10; ch++) begin
          all_k = 1'b1;
          for (int k = 0; k < D; k++) begin
            c = cyc - k;
            s = (c - 2 <= last_rst) ? 1'b0 : hs[(c - 2) % 64][ch];
            if (s == m_slev[ch]) all_k = 1'b0;
          end
          if (all_k) slev_n[ch] = ~m_slev[ch];
        end
      end
      rise = klev_n & ~m_klev;
      clr  = (we && in_win && off == 9'h104) ? wdata[3:0] : 4'h0;
`ifdef NIU32_IO_IRQ_EN
      m_irq = |(m_edge & m_mask);
`else
      m_irq = 1'b0;
`endif
      if (re && in_win) begin
        m_rdata  = model_read(off);
        m_rvalid = 1'b1;
      end else begin
        m_rvalid = 1'b0;
      end
      if (we && in_win) begin
        case (off)
          9'h000: m_hex  = wdata[15:0];
          9'h020: m_ledr = wdata[9:0];
          9'h040: m_ledg = wdata[7:0];
`ifdef NIU32_IO_IRQ_EN
          9'h108: m_mask = wdata[3:0];
`endif
          default: ;
        endcase
      end
      m_edge = (m_edge & ~clr) | rise;
      m_klev = klev_n;
      m_slev = slev_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    step();
    we = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a);
    addr = a; re = 1'b1;
    step();
    re = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [8:0] offs [7];
    offs = '{9'h000, 9'h020, 9'h040, 9'h100, 9'h104, 9'h108, 9'h120};
    reset = 1'b1; KEY = 4'hF; SWITCH = 10'h0; we = 1'b0; re = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (3) step();
    reset = 1'b0;
    checks++; if ({LEDR, LEDG, hex_value, irq, rvalid} !== 35'h0) begin errors++;
      $display("FAIL reset_outputs: got %h want 0", {LEDR, LEDG, hex_value, irq, rvalid}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    for (int i = 0; i < 7; i++) begin
      do_read(BASE + {23'h0, offs[i]});
      checks++; if (rdata !== 32'h0 || rvalid !== 1'b1) begin errors++;
        $display("FAIL reset_read off=%h: got rdata=%h rvalid=%b want 0/1", offs[i], rdata, rvalid); end
      step();
      checks++; if (rvalid !== 1'b0) begin errors++;
        $display("FAIL rvalid_pulse off=%h: got %b want 0", offs[i], rvalid); end
    end
  endtask

  task automatic test_hex_ledr();
    do_write(BASE, 32'h0000BEEF);
    checks++; if (hex_value !== 16'hBEEF) begin errors++; $display("FAIL hex_out: got %h want beef", hex_value); end
    do_read(BASE);
    checks++; if (rdata !== 32'h0000BEEF) begin errors++; $display("FAIL hex_read: got %h want 0000beef", rdata); end
    do_write(BASE + 32'h20, 32'hFFFFFFFF);
    checks++; if (LEDR !== 10'h3FF) begin errors++; $display("FAIL ledr_out: got %h want 3ff", LEDR); end
    do_read(BASE + 32'h22);
    checks++; if (rdata !== 32'h3FF) begin errors++; $display("FAIL ledr_read: got %h want 3ff", rdata); end
  endtask

  task automatic test_debounce_key();
    logic [31:0] exp;
    KEY = 4'b1011;
    repeat (3) step();
    KEY = 4'hF;
    repeat (10) step();
    do_read(BASE + 32'h100);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_level: got %h want 0", rdata); end
    do_read(BASE + 32'h104);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL glitch_edge: got %h want 0", rdata); end
    // Held press: rdata sampled in cycle N+1+j reports the level during N+j.
    KEY = 4'b1011; addr = BASE + 32'h100; re = 1'b1;
    for (int j = 0; j < 9; j++) begin
      step();
      exp = (j >= 6) ? 32'h4 : 32'h0;
      checks++; if (rdata !== exp || rdata !== m_rdata) begin errors++;
        $display("FAIL press_latency j=%0d: got %h want %h (model %h)", j, rdata, exp, m_rdata); end
    end
    re = 1'b0;
    do_read(BASE + 32'h104);
    checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL press_edge: got %h want 4", rdata); end
    KEY = 4'hF;
    repeat (10) step();
    do_read(BASE + 32'h100);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL release_level: got %h want 0", rdata); end
  endtask

  task automatic test_edge_set_wins();
    KEY = 4'b1011;
    repeat (5) step();
    addr = BASE + 32'h104; wdata = 32'h4; we = 1'b1;
    step();
    we = 1'b0;
    do_read(BASE + 32'h104);
    checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL edge_set_wins: got %h want 4", rdata); end
    do_write(BASE + 32'h104, 32'h4);
    do_read(BASE + 32'h104);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL edge_w1c: got %h want 0", rdata); end
    KEY = 4'hF;
    repeat (10) step();
  endtask

  task automatic test_irq();
    logic exp;
    do_write(BASE + 32'h104, 32'hF);
    do_write(BASE + 32'h108, 32'h4);
    do_read(BASE + 32'h108);
`ifdef NIU32_IO_IRQ_EN
    checks++; if (rdata !== 32'h4) begin errors++; $display("FAIL mask_read: got %h want 4", rdata); end
`else
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL mask_read: got %h want 0", rdata); end
`endif
    KEY = 4'b1011;
    for (int j = 0; j < 8; j++) begin
      step();
`ifdef NIU32_IO_IRQ_EN
      exp = (j >= 6);
`else
      exp = 1'b0;
`endif
      checks++; if (irq !== exp || irq !== m_irq) begin errors++;
        $display("FAIL irq_rise j=%0d: got %b want %b", j, irq, exp); end
    end
    do_write(BASE + 32'h104, 32'h4);
`ifdef NIU32_IO_IRQ_EN
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", irq); end
`endif
    step();
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
    KEY = 4'hF;
    repeat (10) step();
  endtask

  task automatic test_window();
    do_read(BASE + 32'h20);
    checks++; if (rdata !== 32'h3FF) begin errors++; $display("FAIL window_pre: got %h want 3ff", rdata); end
    do_read(BASE + 32'h180);
    checks++; if (rdata !== 32'h0 || rvalid !== 1'b1) begin errors++;
      $display("FAIL hole_read: got rdata=%h rvalid=%b want 0/1", rdata, rvalid); end
    do_read(BASE + 32'h20);
    addr = 32'h00001000; re = 1'b1;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL miss_hit: got %b want 0", hit); end
    step();
    re = 1'b0;
    checks++; if (rvalid !== 1'b0 || rdata !== 32'h3FF) begin errors++;
      $display("FAIL miss_read: got rvalid=%b rdata=%h want 0/3ff", rvalid, rdata); end
    addr = BASE + 32'h1FF; #1;
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL hit_top: got %b want 1", hit); end
    addr = BASE + 32'h200; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_above: got %b want 0", hit); end
    addr = BASE - 32'h1; #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("FAIL hit_below: got %b want 0", hit); end
    do_write(32'h00000020, 32'h0);
    checks++; if (LEDR !== 10'h3FF) begin errors++; $display("FAIL miss_write: got %h want 3ff", LEDR); end
    do_write(BASE + 32'h40, 32'h55);
    addr = BASE + 32'h40; wdata = 32'hAA; we = 1'b1; re = 1'b1;
    step();
    we = 1'b0; re = 1'b0;
    checks++; if (rdata !== 32'h55 || LEDG !== 8'hAA) begin errors++;
      $display("FAIL rw_same: got rdata=%h LEDG=%h want 55/aa", rdata, LEDG); end
  endtask

  task automatic test_switch_reset();
    logic [31:0] exp;
    SWITCH = 10'h3FF;
    repeat (4) step();
    reset = 1'b1;
    step();
    reset = 1'b0; addr = BASE + 32'h120; re = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      exp = (j >= 6) ? 32'h3FF : 32'h0;
      checks++; if (rdata !== exp || rdata !== m_rdata) begin errors++;
        $display("FAIL sw_after_reset j=%0d: got %h want %h (model %h)", j, rdata, exp, m_rdata); end
    end
    re = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] pool [11];
    pool = '{BASE, BASE + 32'h20, BASE + 32'h40, BASE + 32'h100, BASE + 32'h104,
             BASE + 32'h108, BASE + 32'h120, BASE + 32'h180, BASE + 32'h1FE,
             BASE + 32'h22, 32'h00000020};
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(4) == 0) KEY[b] = ~KEY[b];
      for (int b = 0; b < 10; b++) if ($urandom_range(7) == 0) SWITCH[b] = ~SWITCH[b];
      reset = ($urandom_range(149) == 0);
      re    = ($urandom_range(2) == 0);
      we    = ($urandom_range(2) == 0);
      addr  = pool[$urandom_range(10)];
      wdata = $urandom;
      step();
      checks++;
      if (LEDR !== m_ledr || LEDG !== m_ledg || hex_value !== m_hex || irq !== m_irq ||
          rvalid !== m_rvalid || rdata !== m_rdata) begin
        errors++;
        $display("FAIL random n=%0d: got ledr=%h ledg=%h hex=%h irq=%b rv=%b rd=%h want %h %h %h %b %b %h",
                 n, LEDR, LEDG, hex_value, irq, rvalid, rdata,
                 m_ledr, m_ledg, m_hex, m_irq, m_rvalid, m_rdata);
      end
    end
    reset = 1'b0; we = 1'b0; re = 1'b0;
  endtask

  initial begin
    test_reset();
    test_hex_ledr();
    test_debounce_key();
    test_edge_set_wins();
    test_irq();
    test_window();
    test_switch_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
